// File: rtl/entropy_ctrl_pkg.sv
// Shared types and constants for the entropy encoder stage-1/2/3 sequencing controller.
package entropy_ctrl_pkg;

    localparam int unsigned DefRangeWidth = 16;
    localparam int unsigned DefDSize      = 5;
    localparam int unsigned DefCntWidth   = 32;

    localparam logic [15:0] RANGE_INIT = 16'h8000;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StFlush
    } ctrl_state_e;

endpackage

// File: rtl/entropy_ctrl_stats.sv
// Per-frame symbol/bit counters and the sticky range-error flag.
module entropy_ctrl_stats
    import entropy_ctrl_pkg::*;
#(
    parameter int unsigned D_SIZE    = DefDSize,
    parameter int unsigned CNT_WIDTH = DefCntWidth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adv,
    input  logic                 clear,
    input  logic [D_SIZE-1:0]    d_in,
    input  logic                 range_msb,
    output logic [CNT_WIDTH-1:0] sym_count,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic                 range_err
);

    logic [CNT_WIDTH-1:0] sym_q, sym_d;
    logic [CNT_WIDTH-1:0] bit_q, bit_d;
    logic                 err_q, err_d;

    always_comb begin
        sym_d = sym_q;
        bit_d = bit_q;
        err_d = err_q;
        if (clear) begin
            sym_d = '0;
            bit_d = '0;
        end else if (adv) begin
            sym_d = sym_q + CNT_WIDTH'(1);
            bit_d = bit_q + CNT_WIDTH'(d_in);
        end
        // A renormalized range must keep its MSB set; the flag survives frame flushes.
        if (adv && !range_msb) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_q <= '0;
            bit_q <= '0;
            err_q <= 1'b0;
        end else begin
            sym_q <= sym_d;
            bit_q <= bit_d;
            err_q <= err_d;
        end
    end

    assign sym_count = sym_q;
    assign bit_count = bit_q;
    assign range_err = err_q;

endmodule

// File: rtl/entropy_stage_ctrl.sv
// Pipeline valid/handshake sequencing, fed-back range register and end-of-frame
// drain/flush FSM for the stage-1 -> stage-2 -> stage-3 entropy datapath.
module entropy_stage_ctrl
    import entropy_ctrl_pkg::*;
#(
    parameter int unsigned RANGE_WIDTH = DefRangeWidth,
    parameter int unsigned D_SIZE      = DefDSize,
    parameter int unsigned CNT_WIDTH   = DefCntWidth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   p1_en,
    output logic                   p2_en,
    output logic [RANGE_WIDTH-1:0] range_q,
    input  logic [RANGE_WIDTH-1:0] range_next,
    input  logic [D_SIZE-1:0]      d_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   flush_req,
    input  logic                   flush_ack,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   sym_count,
    output logic [CNT_WIDTH-1:0]   bit_count,
    output logic                   range_err
);

    // Half-scale range: MSB set, remaining bits clear.
    localparam logic [RANGE_WIDTH-1:0] RangeReset =
        (RANGE_WIDTH == 16) ? RANGE_WIDTH'(RANGE_INIT) : {1'b1, {(RANGE_WIDTH-1){1'b0}}};

    ctrl_state_e            state_q, state_d;
    logic                   p1_valid_q, p1_valid_d;
    logic                   p2_valid_q, p2_valid_d;
    logic [RANGE_WIDTH-1:0] range_d;
    logic                   adv;
    logic                   flush_done;

    assign adv        = p1_valid_q & (~p2_valid_q | out_ready);
    assign flush_done = (state_q == StFlush) & flush_ack;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        flush_req = 1'b0;
        unique case (state_q)
            StRun: begin
                in_ready = ~p1_valid_q | adv;
            end
            StDrain: begin
                if (!p1_valid_q && !p2_valid_q) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                flush_req = 1'b1;
                if (flush_ack) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        p1_en = in_valid & in_ready;
        if (p1_en && in_last) begin
            state_d = StDrain;
        end
    end

    always_comb begin
        p1_valid_d = p1_en | (p1_valid_q & ~adv);
        p2_valid_d = adv | (p2_valid_q & ~out_ready);
        range_d    = range_q;
        if (flush_done) begin
            range_d = RangeReset;
        end else if (adv) begin
            range_d = range_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            p1_valid_q <= 1'b0;
            p2_valid_q <= 1'b0;
            range_q    <= RangeReset;
        end else begin
            state_q    <= state_d;
            p1_valid_q <= p1_valid_d;
            p2_valid_q <= p2_valid_d;
            range_q    <= range_d;
        end
    end

    assign p2_en     = adv;
    assign out_valid = p2_valid_q;
    assign busy      = (state_q != StRun) | p1_valid_q | p2_valid_q;

    entropy_ctrl_stats #(
        .D_SIZE   (D_SIZE),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stats (
        .clk      (clk),
        .reset    (reset),
        .adv      (adv),
        .clear    (flush_done),
        .d_in     (d_in),
        .range_msb(range_next[RANGE_WIDTH-1]),
        .sym_count(sym_count),
        .bit_count(bit_count),
        .range_err(range_err)
    );

endmodule

// File: tb/tb_entropy_stage_ctrl.sv
// Scoreboard bench for entropy_stage_ctrl: symbols tracked through P1/P2 queues.
module tb_entropy_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_last, in_ready, p1_en, p2_en;
    logic [15:0] range_q, range_next;
    logic [4:0]  d_in;
    logic        out_valid, out_ready, flush_req, flush_ack, busy, range_err;
    logic [31:0] sym_count, bit_count;

    always #5 clk = ~clk;

    entropy_stage_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .p1_en     (p1_en),
        .p2_en     (p2_en),
        .range_q   (range_q),
        .range_next(range_next),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush_req (flush_req),
        .flush_ack (flush_ack),
        .busy      (busy),
        .sym_count (sym_count),
        .bit_count (bit_count),
        .range_err (range_err)
    );

    typedef struct packed {
        logic [15:0] rng;
        logic [4:0]  d;
        logic        lst;
    } sym_t;

    sym_t        src_q[$];
    sym_t        p1_q[$];
    sym_t        p2_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          sent    = 0;
    int          delivered = 0;
    logic [31:0] exp_sym, exp_bit;
    logic [15:0] exp_range;
    logic        exp_err;
    logic        ack_drv;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_sym(input logic [15:0] r, input logic [4:0] d, input logic l);
        sym_t s;
        s.rng = r;
        s.d   = d;
        s.lst = l;
        src_q.push_back(s);
    endtask

    // One clock cycle: drive inputs, predict handshakes, advance the scoreboard, check state.
    task automatic tick();
        logic acc, exp_adv, popped, flushed;
        sym_t s;
        in_valid = (src_q.size() > 0);
        in_last  = (src_q.size() > 0) ? src_q[0].lst : 1'b0;
        if (p1_q.size() > 0) begin
            range_next = p1_q[0].rng;
            d_in       = p1_q[0].d;
        end else begin
            range_next = 16'h5555;
            d_in       = 5'd0;
        end
        flush_ack = ack_drv;
        #1;
        acc     = in_valid & in_ready;
        exp_adv = (p1_q.size() > 0) && ((p2_q.size() == 0) || out_ready);
        popped  = (p2_q.size() > 0) && out_ready;
        flushed = flush_req & flush_ack;
        if (!reset) begin
            check_val("p2_en", 32'(p2_en), 32'(exp_adv));
            check_val("p1_en", 32'(p1_en), 32'(acc));
        end
        @(posedge clk);
        #1;
        if (reset) begin
            src_q.delete();
            p1_q.delete();
            p2_q.delete();
            exp_range = 16'h8000;
            exp_sym   = '0;
            exp_bit   = '0;
            exp_err   = 1'b0;
        end else begin
            if (popped) begin
                void'(p2_q.pop_front());
                delivered++;
            end
            if (exp_adv) begin
                s = p1_q.pop_front();
                p2_q.push_back(s);
                exp_range = s.rng;
                exp_sym   = exp_sym + 32'd1;
                exp_bit   = exp_bit + 32'(s.d);
                if (!s.rng[15]) exp_err = 1'b1;
            end
            if (acc) begin
                p1_q.push_back(src_q.pop_front());
                sent++;
            end
            if (flushed) begin
                exp_range = 16'h8000;
                exp_sym   = '0;
                exp_bit   = '0;
            end
        end
        check_val("range_q", 32'(range_q), 32'(exp_range));
        check_val("sym_count", sym_count, exp_sym);
        check_val("bit_count", bit_count, exp_bit);
        check_val("range_err", 32'(range_err), 32'(exp_err));
        check_val("out_valid", 32'(out_valid), 32'(p2_q.size() != 0));
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((src_q.size() + p1_q.size() + p2_q.size()) != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check_val("idle_timeout", 32'((src_q.size() + p1_q.size() + p2_q.size()) != 0), 32'd0);
    endtask

    task automatic wait_flush(input int max_cycles);
        int n = 0;
        while (!flush_req && n < max_cycles) begin
            tick();
            check_val("drain_in_ready", 32'(in_ready), 32'd0);
            check_val("drain_busy", 32'(busy), 32'd1);
            n++;
        end
        check_val("flush_timeout", 32'(flush_req), 32'd1);
        check_val("flush_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic do_ack();
        ack_drv = 1'b1;
        tick();
        ack_drv = 1'b0;
        check_val("ack_flush_req", 32'(flush_req), 32'd0);
        check_val("ack_in_ready", 32'(in_ready), 32'd1);
        check_val("ack_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        range_next = '0;
        d_in       = '0;
        out_ready  = 1'b1;
        flush_ack  = 1'b0;
        ack_drv    = 1'b0;
        exp_range  = 16'h8000;
        exp_sym    = '0;
        exp_bit    = '0;
        exp_err    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Post-reset idle
        check_val("idle_range", 32'(range_q), 32'h8000);
        check_val("idle_in_ready", 32'(in_ready), 32'd1);
        check_val("idle_out_valid", 32'(out_valid), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_flush_req", 32'(flush_req), 32'd0);

        // Back-to-back stream
        push_sym(16'h9A00, 5'd1, 1'b0);
        push_sym(16'h8800, 5'd2, 1'b0);
        push_sym(16'hF000, 5'd0, 1'b0);
        push_sym(16'hC100, 5'd3, 1'b0);
        tick();
        check_val("b2b_latency", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("b2b_stream", 32'(out_valid), 32'd1);
        end
        tick();
        check_val("b2b_end", 32'(out_valid), 32'd0);
        check_val("b2b_sym", sym_count, 32'd4);
        check_val("b2b_bit", bit_count, 32'd6);
        check_val("b2b_range", 32'(range_q), 32'hC100);

        // Back-pressure
        push_sym(16'hE000, 5'd4, 1'b0);
        push_sym(16'hD000, 5'd5, 1'b0);
        push_sym(16'hB000, 5'd6, 1'b0);
        tick();
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            check_val("bp_range", 32'(range_q), 32'hE000);
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        run_until_idle(20);
        check_val("bp_sym", sym_count, 32'd7);
        check_val("bp_bit", bit_count, 32'd21);
        check_val("bp_no_loss", 32'(delivered), 32'(sent));

        // Frame end, drain and flush
        push_sym(16'h9000, 5'd1, 1'b0);
        push_sym(16'hA000, 5'd2, 1'b1);
        tick();
        tick();
        check_val("fe_in_ready", 32'(in_ready), 32'd0);
        wait_flush(20);
        check_val("fe_sym", sym_count, 32'd9);
        check_val("fe_bit", bit_count, 32'd24);
        tick();
        check_val("fe_flush_level", 32'(flush_req), 32'd1);
        do_ack();
        check_val("fe_range", 32'(range_q), 32'h8000);
        check_val("fe_sym_clr", sym_count, 32'd0);
        check_val("fe_bit_clr", bit_count, 32'd0);

        // Range error, sticky across flush
        push_sym(16'h7FFF, 5'd0, 1'b1);
        wait_flush(20);
        check_val("err_set", 32'(range_err), 32'd1);
        do_ack();
        check_val("err_sticky", 32'(range_err), 32'd1);

        // Reset in FLUSH, then a late ack in RUN
        push_sym(16'h8800, 5'd3, 1'b1);
        wait_flush(20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_range", 32'(range_q), 32'h8000);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_flush_req", 32'(flush_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_err", 32'(range_err), 32'd0);
        check_val("rst_sym", sym_count, 32'd0);
        push_sym(16'hC100, 5'd7, 1'b0);
        run_until_idle(10);
        ack_drv = 1'b1;
        tick();
        ack_drv = 1'b0;
        check_val("late_ack_sym", sym_count, 32'd1);
        check_val("late_ack_bit", bit_count, 32'd7);
        check_val("late_ack_range", 32'(range_q), 32'hC100);
        check_val("late_ack_in_ready", 32'(in_ready), 32'd1);
        check_val("late_ack_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
